// File: rtl/data_c_pipe_skid.sv
// Single-entry skid buffer for a valid/ready stream: registered ready, pass-through valid/data/side.
// Optional stall/skid statistics counters enabled by DATA_C_PIPE_SKID_STATS_EN.
module data_c_pipe_skid #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned SSIZE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic [SSIZE-1:0] in_side,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [SSIZE-1:0] out_side,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] skid_cnt
);

  typedef enum logic {PASS = 1'b0, SKID = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [DSIZE-1:0] skid_data_q;
  logic [SSIZE-1:0] skid_side_q;
  logic             capture;

  // A beat accepted while downstream is stalled must be parked in the skid register.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      PASS: begin
        if (in_valid && in_ready_q && !out_ready) begin
          state_d = SKID;
          capture = 1'b1;
        end
      end
      SKID: begin
        if (out_ready) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PASS;
      in_ready_q  <= 1'b0;
      skid_data_q <= '0;
      skid_side_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == PASS);
      if (capture) begin
        skid_data_q <= in_data;
        skid_side_q <= in_side;
      end
    end
  end

  assign in_ready = in_ready_q;

  always_comb begin
    if (state_q == SKID) begin
      out_valid = 1'b1;
      out_data  = skid_data_q;
      out_side  = skid_side_q;
    end else begin
      out_valid = in_valid && in_ready_q;
      out_data  = in_data;
      out_side  = in_side;
    end
  end

`ifdef DATA_C_PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] skid_cnt_q;

  // Saturating counters: they stop at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      skid_cnt_q  <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (capture && !(&skid_cnt_q)) skid_cnt_q <= skid_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign skid_cnt  = skid_cnt_q;
`else
  assign stall_cnt = '0;
  assign skid_cnt  = '0;
`endif

endmodule
